// File: rtl/clkdiv_pkg.sv
// Shared types and defaults for the divided-clock monitor and the divider benches.
package clkdiv_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARM     = 2'd1,
      MEASURE = 2'd2,
      DONE    = 2'd3
   } clkdiv_state_e;

   localparam int CLKDIV_CNT_W       = 16;
   localparam int CLKDIV_TIMEOUT     = 65535;
   localparam int CLKDIV_SYNC_STAGES = 2;

endpackage

// File: rtl/clkdiv_sync_edge.sv
// Multi-flop synchronizer for an asynchronous level, followed by a history flop
// for single-cycle rise/fall strobes in the clk domain.
module clkdiv_sync_edge
   import clkdiv_pkg::*;
#(
   parameter int SYNC_STAGES = CLKDIV_SYNC_STAGES
) (
   input  logic clk,
   input  logic rstn,
   input  logic sig_in,
   output logic sync,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync_d, sync_q;
   logic                   hist_d, hist_q;

   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], sig_in};
      hist_d = sync_q[SYNC_STAGES-1];
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sync_q <= '0;
         hist_q <= 1'b0;
      end else begin
         sync_q <= sync_d;
         hist_q <= hist_d;
      end
   end

   assign sync = sync_q[SYNC_STAGES-1];
   assign rise = sync & ~hist_q;
   assign fall = ~sync & hist_q;

endmodule

// File: rtl/clkdiv_monitor.sv
// Measures period and high time of a divided clock in clk cycles and returns
// the result over valid/ready; a missing edge ends the measurement with timeout.
module clkdiv_monitor
   import clkdiv_pkg::*;
#(
   parameter int CNT_W       = CLKDIV_CNT_W,
   parameter int TIMEOUT     = CLKDIV_TIMEOUT,
   parameter int SYNC_STAGES = CLKDIV_SYNC_STAGES
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             sig_in,
   input  logic             start,
   output logic             busy,
   output logic             meas_valid,
   input  logic             meas_ready,
   output logic [CNT_W-1:0] period,
   output logic [CNT_W-1:0] high_time,
   output logic             timeout
);

   localparam logic [CNT_W-1:0] TMO      = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

   clkdiv_state_e    state_d, state_q;
   logic [CNT_W-1:0] cnt_d, cnt_q;
   logic [CNT_W-1:0] period_d, period_q;
   logic [CNT_W-1:0] high_d, high_q;
   logic             timeout_d, timeout_q;
   logic             busy_d, busy_q;
   logic             valid_d, valid_q;
   logic             sig_rise, sig_fall;

   clkdiv_sync_edge #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync_edge (
      .clk    (clk),
      .rstn   (rstn),
      .sig_in (sig_in),
      .sync   (),
      .rise   (sig_rise),
      .fall   (sig_fall)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      period_d  = period_q;
      high_d    = high_q;
      timeout_d = timeout_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d   = ARM;
               cnt_d     = '0;
               timeout_d = 1'b0;
            end
         end
         // ARM enters with cnt=0, so the wait has lasted TIMEOUT cycles once cnt hits TIMEOUT-1.
         ARM: begin
            if (sig_rise) begin
               state_d = MEASURE;
               cnt_d   = ONE;
            end else if (cnt_q == TMO_LAST) begin
               state_d   = DONE;
               timeout_d = 1'b1;
               period_d  = '0;
               high_d    = '0;
            end else begin
               cnt_d = cnt_q + ONE;
            end
         end
         MEASURE: begin
            cnt_d = cnt_q + ONE;
            if (sig_fall) high_d = cnt_q;
            if (sig_rise) begin
               period_d = cnt_q;
               state_d  = DONE;
            end else if (cnt_q == TMO) begin
               state_d   = DONE;
               timeout_d = 1'b1;
               period_d  = '0;
               high_d    = '0;
            end
         end
         DONE: begin
            if (meas_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      busy_d  = (state_d != IDLE);
      valid_d = (state_d == DONE);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         period_q  <= '0;
         high_q    <= '0;
         timeout_q <= 1'b0;
         busy_q    <= 1'b0;
         valid_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         period_q  <= period_d;
         high_q    <= high_d;
         timeout_q <= timeout_d;
         busy_q    <= busy_d;
         valid_q   <= valid_d;
      end
   end

   assign busy       = busy_q;
   assign meas_valid = valid_q;
   assign period     = period_q;
   assign high_time  = high_q;
   assign timeout    = timeout_q;

endmodule
